// File: rtl/vga_scan_ctrl.sv
// VGA raster scan generator: pixel-tick divider, x/y scan counters, frame counter,
// and a one-pixel-latency colour/sync output stage with a per-frame vblank strobe.
module vga_scan_ctrl #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  pix_rgb,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        video_on,
    output logic        pix_tick,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        vblank_start,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] Y_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = !SYNC_ACT;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic [15:0]      frame_q, frame_d;
    logic [3:0]       r_q, r_d;
    logic [3:0]       g_q, g_d;
    logic [3:0]       b_q, b_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    logic tick;
    logic vis;
    logic in_hsync;
    logic in_vsync;

    assign tick     = (div_q == DIV_LAST);
    assign vis      = (x_q < X_VIS) && (y_q < Y_VIS);
    assign in_hsync = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    assign in_vsync = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

    // Pixel divider and raster position; everything advances only on the tick.
    always_comb begin
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d     = '0;
                    frame_d = frame_q + 16'd1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // Output stage samples the pixel being retired, so colour and sync share one pixel of latency.
    always_comb begin
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (tick) begin
            r_d     = vis ? {4{pix_rgb[2]}} : 4'h0;
            g_d     = vis ? {4{pix_rgb[1]}} : 4'h0;
            b_d     = vis ? {4{pix_rgb[0]}} : 4'h0;
            hsync_d = in_hsync ? SYNC_ACT : SYNC_IDLE;
            vsync_d = in_vsync ? SYNC_ACT : SYNC_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            hsync_q <= SYNC_IDLE;
            vsync_q <= SYNC_IDLE;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign x            = x_q;
    assign y            = y_q;
    assign video_on     = vis;
    assign pix_tick     = tick;
    assign vga_r        = r_q;
    assign vga_g        = g_q;
    assign vga_b        = b_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign vblank_start = tick && (x_q == X_LAST) && (y_q == Y_VIS_LAST);
    assign frame_cnt    = frame_q;

endmodule
